// File: rtl/conv_window_memory.sv
// Serial loader for an N x N tile and a K x K filter; streams every stride-1
// K x K window of the tile row-major over a valid/ready handshake.
module conv_window_memory #(
  parameter int DW = 8,
  parameter int N  = 4,
  parameter int K  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic              load_done,
  output logic [K*K*DW-1:0] filt_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output logic [((N-K+1) > 1 ? $clog2(N-K+1) : 1)-1:0] win_row,
  output logic [((N-K+1) > 1 ? $clog2(N-K+1) : 1)-1:0] win_col,
  output logic              win_last,
  output logic              busy
);
  localparam int M  = N - K + 1;
  localparam int RW = (M > 1) ? $clog2(M) : 1;
  localparam int TW = (N * N > 1) ? $clog2(N * N) : 1;
  localparam int FW = (K * K > 1) ? $clog2(K * K) : 1;

  // states: IDLE wait start | LOAD_D tile fill | LOAD_F filter fill | SCAN stream windows
  typedef enum logic [1:0] {IDLE, LOAD_D, LOAD_F, SCAN} state_t;

  state_t          state, next_state;
  logic [TW-1:0]   cnt;
  logic [RW-1:0]   row, col;
  logic [DW-1:0]   tile [N*N];
  logic [DW-1:0]   filt [K*K];
  logic [TW-1:0]   idx;
  logic            accept;

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state == LOAD_D) || (state == LOAD_F);
  assign win_valid = (state == SCAN);
  assign busy      = (state != IDLE);
  assign win_last  = (state == SCAN) && (row == RW'(M - 1)) && (col == RW'(M - 1));
  assign win_row   = row;
  assign win_col   = col;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_D;
      LOAD_D:  if (accept && cnt == TW'(N * N - 1)) next_state = LOAD_F;
      LOAD_F:  if (accept && cnt == TW'(K * K - 1)) next_state = SCAN;
      SCAN:    if (win_ready && win_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      row       <= '0;
      col       <= '0;
      load_done <= 1'b0;
      for (int i = 0; i < N * N; i++) tile[i] <= '0;
      for (int i = 0; i < K * K; i++) filt[i] <= '0;
    end else begin
      load_done <= (state == LOAD_F) && (next_state == SCAN);
      case (state)
        IDLE: if (start) cnt <= '0;
        LOAD_D: if (accept) begin
          tile[cnt] <= in_data;
          cnt <= (cnt == TW'(N * N - 1)) ? '0 : cnt + TW'(1);
        end
        LOAD_F: if (accept) begin
          filt[cnt[FW-1:0]] <= in_data;
          cnt <= cnt + TW'(1);
          if (cnt == TW'(K * K - 1)) begin
            row <= '0;
            col <= '0;
          end
        end
        SCAN: if (win_ready) begin
          // the final handshake leaves row/col parked at the origin
          if (col == RW'(M - 1)) begin
            col <= '0;
            row <= win_last ? '0 : row + RW'(1);
          end else begin
            col <= col + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    idx       = '0;
    win_data  = '0;
    filt_data = '0;
    for (int i = 0; i < K; i++) begin
      for (int j = 0; j < K; j++) begin
        idx = TW'((int'(row) + i) * N + int'(col) + j);
        win_data[(i*K+j)*DW +: DW]  = tile[idx];
        filt_data[(i*K+j)*DW +: DW] = filt[i*K+j];
      end
    end
  end
endmodule
